// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state encoding and address helpers for the
// 11-tap FIR engine (fir_engine, fir_mac).
//
// Contents:
//   DATA_W   sample / tap / result width
//   NUM_TAP  number of taps, and depth of the circular data RAM
//   ADDR_W   byte-address width of both BRAMs
//   IDX_W    width of a word index (0..NUM_TAP-1) or a sequencing step
//   state_t  engine states IDLE, CLEAR, WAIT_IN, MAC, OUT, DONE
//   circ_idx (base - k) mod NUM_TAP, for base and k both in 0..NUM_TAP-1
//   byte_addr word index -> BRAM byte address (index << 2)
package fir_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_TAP = 11;
    localparam int ADDR_W  = 12;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WAIT_IN = 3'd2,
        MAC     = 3'd3,
        OUT     = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Circular look-back into the sample buffer. Both operands are below
    // NUM_TAP, so a single conditional add of NUM_TAP is enough. The 4-bit
    // intermediate may wrap, but the final result always lands in 0..10,
    // so modulo-16 arithmetic gives the right answer.
    function automatic logic [IDX_W-1:0] circ_idx(
        input logic [IDX_W-1:0] base,
        input logic [IDX_W-1:0] k
    );
        logic [IDX_W-1:0] r;
        if (base >= k) begin
            r = base - k;
        end else begin
            r = base + IDX_W'(NUM_TAP) - k;
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [IDX_W-1:0] idx);
        return {{(ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (acc -> 0)
//   clr         synchronous clear of the accumulator (wins over en)
//   en          accumulate a*b on this edge
//   a, b        signed operands
//   acc         accumulator, wraps modulo 2^DATA_W
module fir_mac
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;
    logic signed [DATA_W-1:0] prod;

    // Only the low DATA_W bits of the signed product are needed, because
    // the accumulator itself wraps modulo 2^DATA_W.
    assign prod = $signed(a) * $signed(b);

    always_comb begin
        acc_next = acc_reg;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc_reg + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/fir_engine.sv
// fir_engine: 11-tap FIR filter driving a tap BRAM (read only) and a data
// BRAM (circular sample buffer). One output sample per input sample.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   ap_start/ap_idle/ap_done, data_length   block-level run control
//   ss_tvalid/ss_tdata/ss_tlast/ss_tready  input sample stream
//   sm_tvalid/sm_tdata/sm_tlast/sm_tready  output result stream
//   tap_EN/tap_WE/tap_A, tap_Do            tap RAM port (never written)
//   data_EN/data_WE/data_A/data_Di, data_Do data RAM port
//   err_tlast             sticky input-tlast mismatch flag
//
// Build option: define FIR_TLAST_CHECK_EN to enable the ss_tlast check that
// drives err_tlast; otherwise err_tlast is 0 and ss_tlast is ignored.
//
// Timing: the RAMs register address/WE on CLK and return read data one
// cycle later. MAC step j (0..11 after the input handshake) issues the
// address pair for tap j while j <= 10, and accumulates the pair issued on
// step j-1 while j >= 1, so the final product lands on the 12th edge after
// the handshake, which is also the edge that enters OUT.
module fir_engine
    import fir_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              tap_EN,
    output logic [3:0]        tap_WE,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic              data_EN,
    output logic [3:0]        data_WE,
    output logic [ADDR_W-1:0] data_A,
    output logic [DATA_W-1:0] data_Di,
    input  logic [DATA_W-1:0] data_Do,
    output logic              err_tlast
);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  step_reg, step_next;   // CLEAR word / MAC step
    logic [IDX_W-1:0]  wptr_reg, wptr_next;   // slot of the newest sample
    logic [31:0]       count_reg, count_next; // outputs delivered this run
    logic [31:0]       len_reg, len_next;     // data_length latched at start
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] acc;
    logic              last_sample;

    // The sample in flight is the last one of the run.
    assign last_sample = (count_reg + 32'd1 == len_reg);

    assign tap_WE  = 4'h0;
    assign ap_done = (state_reg == DONE);

`ifdef FIR_TLAST_CHECK_EN
    logic err_reg, err_next;
`else
    logic tlast_unused;
    assign tlast_unused = ss_tlast;
`endif

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        wptr_next  = wptr_reg;
        count_next = count_reg;
        len_next   = len_reg;
`ifdef FIR_TLAST_CHECK_EN
        err_next   = err_reg;
`endif
        ap_idle    = 1'b0;
        ss_tready  = 1'b0;
        sm_tvalid  = 1'b0;
        sm_tlast   = 1'b0;
        tap_EN     = 1'b0;
        tap_A      = '0;
        data_EN    = 1'b0;
        data_WE    = 4'h0;
        data_A     = '0;
        data_Di    = '0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_next = CLEAR;
                    step_next  = '0;
                    wptr_next  = '0;
                    count_next = '0;
                    len_next   = data_length;
`ifdef FIR_TLAST_CHECK_EN
                    err_next   = 1'b0;
`endif
                end
            end

            // Zero the whole sample buffer so history from a previous run
            // (or power-up contents) reads as silence.
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = byte_addr(step_reg);
                if (step_reg == IDX_W'(NUM_TAP - 1)) begin
                    step_next  = '0;
                    state_next = (len_reg == 32'd0) ? DONE : WAIT_IN;
                end else begin
                    step_next = step_reg + 1'b1;
                end
            end

            WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN    = 1'b1;
                    data_WE    = 4'hF;
                    data_A     = byte_addr(wptr_reg);
                    data_Di    = ss_tdata;
                    mac_clr    = 1'b1;
                    step_next  = '0;
                    state_next = MAC;
`ifdef FIR_TLAST_CHECK_EN
                    if (ss_tlast != last_sample) begin
                        err_next = 1'b1;
                    end
`endif
                end
            end

            MAC: begin
                if (step_reg <= IDX_W'(NUM_TAP - 1)) begin
                    tap_EN  = 1'b1;
                    tap_A   = byte_addr(step_reg);
                    data_EN = 1'b1;
                    data_A  = byte_addr(circ_idx(wptr_reg, step_reg));
                end
                // Read data trails the address by one cycle.
                mac_en = (step_reg != '0);
                if (step_reg == IDX_W'(NUM_TAP)) begin
                    step_next  = '0;
                    state_next = OUT;
                end else begin
                    step_next = step_reg + 1'b1;
                end
            end

            // sm_tdata comes straight from the accumulator, which is idle
            // here, so data and tlast stay stable under back-pressure.
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = last_sample;
                if (sm_tready) begin
                    wptr_next  = (wptr_reg == IDX_W'(NUM_TAP - 1)) ? '0 : wptr_reg + 1'b1;
                    count_next = count_reg + 32'd1;
                    state_next = last_sample ? DONE : WAIT_IN;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
            len_reg   <= len_next;
        end
    end

`ifdef FIR_TLAST_CHECK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
    assign err_tlast = err_reg;
`else
    assign err_tlast = 1'b0;
`endif

    fir_mac u_mac (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (tap_Do),
        .b     (data_Do),
        .acc   (acc)
    );

    assign sm_tdata = acc;

endmodule

// File: tb/tb_fir_engine.sv
// tb_fir_engine: directed self-checking bench for fir_engine. Models the tap
// and data BRAMs (registered read, byte-lane write), drives directed sample
// sequences with hand-computed expected outputs, and checks latency,
// back-pressure, run control, mid-run reset and the tlast check flag.
module tb_fir_engine;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ap_start = 1'b0;
    logic [31:0] data_length = 32'd0;
    logic        ap_idle, ap_done;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata = 32'd0;
    logic        ss_tlast = 1'b0;
    logic        ss_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        sm_tready = 1'b0;
    logic        tap_EN;
    logic [3:0]  tap_WE;
    logic [11:0] tap_A;
    logic [31:0] tap_Do = 32'd0;
    logic        data_EN;
    logic [3:0]  data_WE;
    logic [11:0] data_A;
    logic [31:0] data_Di;
    logic [31:0] data_Do = 32'd0;
    logic        err_tlast;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] tmem [0:15];
    logic [31:0] dmem [0:15];

    always #5 CLK = ~CLK;

    fir_engine dut (
        .CLK(CLK), .RST_N(RST_N), .ap_start(ap_start), .data_length(data_length),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di),
        .data_Do(data_Do), .err_tlast(err_tlast)
    );

    // BRAM models: address/WE registered on CLK, read-first, data next cycle.
    always @(posedge CLK) begin
        if (tap_EN) tap_Do <= tmem[tap_A[5:2]];
        if (data_EN) begin
            data_Do <= dmem[data_A[5:2]];
            for (int b = 0; b < 4; b++)
                if (data_WE[b]) dmem[data_A[5:2]][8*b +: 8] <= data_Di[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic load_taps(input int mode);
        for (int i = 0; i < 16; i++) tmem[i] = (mode == 0) ? 32'(i + 1) : 32'd1;
    endtask

    // Called at a negedge while the engine is idle/done.
    task automatic start_job(input logic [31:0] len);
        data_length = len;
        ap_start = 1'b1;
        @(negedge CLK);
        ap_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic last);
        int n = 0;
        while (ss_tready !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("ss_tready", {31'd0, ss_tready}, 32'd1);
        ss_tvalid = 1'b1;
        ss_tdata  = x;
        ss_tlast  = last;
        @(negedge CLK);
        ss_tvalid = 1'b0;
        ss_tdata  = 32'd0;
        ss_tlast  = 1'b0;
    endtask

    // Entered at the negedge right after the input handshake edge.
    task automatic recv(input logic [31:0] exp_y, input logic exp_last,
                        input int stall, input bit poke);
        if (poke) ap_start = 1'b1;
        repeat (11) begin
            @(negedge CLK);
            ap_start = 1'b0;
        end
        check("lat_early", {31'd0, sm_tvalid}, 32'd0);
        @(negedge CLK);
        check("lat_valid", {31'd0, sm_tvalid}, 32'd1);
        check("y_data", sm_tdata, exp_y);
        check("y_last", {31'd0, sm_tlast}, {31'd0, exp_last});
        check("ss_blocked", {31'd0, ss_tready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            check("hold_valid", {31'd0, sm_tvalid}, 32'd1);
            check("hold_data", sm_tdata, exp_y);
            check("hold_last", {31'd0, sm_tlast}, {31'd0, exp_last});
        end
        sm_tready = 1'b1;
        @(negedge CLK);
        sm_tready = 1'b0;
        check("post_valid", {31'd0, sm_tvalid}, 32'd0);
    endtask

    logic [31:0] exp2 [0:14];
    logic        exp_err;

    initial begin
        exp2 = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21, 32'd28, 32'd36,
                 32'd45, 32'd55, 32'd66, 32'd77, 32'd88, 32'd99, 32'd110};
        for (int i = 0; i < 16; i++) dmem[i] = 32'hDEAD_0000 + 32'(i);
        load_taps(0);
`ifdef FIR_TLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_idle", {31'd0, ap_idle}, 32'd1);
        check("rst_done", {31'd0, ap_done}, 32'd0);
        check("rst_ss_rdy", {31'd0, ss_tready}, 32'd0);
        check("rst_sm_vld", {31'd0, sm_tvalid}, 32'd0);
        check("rst_en", {30'd0, tap_EN, data_EN}, 32'd0);
        check("rst_we", {24'd0, tap_WE, data_WE}, 32'd0);
        check("rst_addr", {8'd0, tap_A, data_A}, 32'd0);
        check("rst_err", {31'd0, err_tlast}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // T1: impulse response, taps 1..11; ap_start poked during one MAC
        start_job(32'd11);
        for (int n = 0; n < 11; n++) begin
            send((n == 0) ? 32'd1 : 32'd0, n == 10);
            recv(32'(n + 1), n == 10, 0, n == 3);
        end
        check("t1_done", {31'd0, ap_done}, 32'd1);
        check("t1_idle", {31'd0, ap_idle}, 32'd1);
        check("t1_err", {31'd0, err_tlast}, 32'd0);

        // T2: all-ones taps, ramp input, wraps the write pointer
        load_taps(1);
        start_job(32'd15);
        for (int n = 0; n < 15; n++) begin
            send(32'(n + 1), n == 14);
            recv(exp2[n], n == 14, 0, 1'b0);
        end
        check("t2_done", {31'd0, ap_done}, 32'd1);

        // T3: back-to-back jobs; second one must see a cleared buffer,
        // signed samples, and a 5-cycle output stall
        load_taps(0);
        start_job(32'd3);
        send(32'd5, 1'b0); recv(32'd5, 1'b0, 0, 1'b0);
        send(32'd6, 1'b0); recv(32'd16, 1'b0, 0, 1'b0);
        send(32'd7, 1'b1); recv(32'd34, 1'b1, 0, 1'b0);
        start_job(32'd2);
        check("t3_done_clr", {31'd0, ap_done}, 32'd0);
        send(32'hFFFF_FFFD, 1'b0); recv(32'hFFFF_FFFD, 1'b0, 5, 1'b0);
        send(32'd4, 1'b1);         recv(32'hFFFF_FFFE, 1'b1, 0, 1'b0);
        check("t3_done", {31'd0, ap_done}, 32'd1);

        // T4: zero-length run: only the 11 clear cycles, then DONE
        start_job(32'd0);
        check("t4_done_lo", {31'd0, ap_done}, 32'd0);
        check("t4_clr_we", {28'd0, data_WE}, 32'h0000_000F);
        repeat (10) begin
            @(negedge CLK);
            check("t4_no_valid", {31'd0, sm_tvalid}, 32'd0);
        end
        check("t4_not_yet", {31'd0, ap_done}, 32'd0);
        @(negedge CLK);
        check("t4_done", {31'd0, ap_done}, 32'd1);
        check("t4_idle", {31'd0, ap_idle}, 32'd1);

        // T5: asynchronous reset in the middle of MAC, then a clean run
        start_job(32'd3);
        send(32'd5, 1'b0);
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("t5_idle", {31'd0, ap_idle}, 32'd1);
        check("t5_done", {31'd0, ap_done}, 32'd0);
        check("t5_en", {30'd0, tap_EN, data_EN}, 32'd0);
        check("t5_addr", {8'd0, tap_A, data_A}, 32'd0);
        check("t5_vld", {30'd0, sm_tvalid, ss_tready}, 32'd0);
        check("t5_tdata", sm_tdata, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        start_job(32'd2);
        send(32'd2, 1'b0); recv(32'd2, 1'b0, 0, 1'b0);
        send(32'd3, 1'b1); recv(32'd7, 1'b1, 0, 1'b0);
        check("t5_again", {31'd0, ap_done}, 32'd1);

        // T6: early ss_tlast on sample 3 of 5
        start_job(32'd5);
        send(32'd1, 1'b0); recv(32'd1, 1'b0, 0, 1'b0);
        send(32'd1, 1'b0); recv(32'd3, 1'b0, 0, 1'b0);
        send(32'd1, 1'b1);
        check("t6_err_set", {31'd0, err_tlast}, {31'd0, exp_err});
        recv(32'd6, 1'b0, 0, 1'b0);
        send(32'd1, 1'b0); recv(32'd10, 1'b0, 0, 1'b0);
        send(32'd1, 1'b1); recv(32'd15, 1'b1, 0, 1'b0);
        check("t6_err_stky", {31'd0, err_tlast}, {31'd0, exp_err});
        start_job(32'd0);
        check("t6_err_clr", {31'd0, err_tlast}, 32'd0);
        repeat (12) @(negedge CLK);
        check("t6_done", {31'd0, ap_done}, 32'd1);
        check("tap_we", {28'd0, tap_WE}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fir_engine.md
Name: fir_engine

Overview:
- Datapath/control stage directly upstream of, and consuming, the two 11-word byte-addressed BRAMs: tap RAM (read-only here) and data RAM (written here as a circular sample buffer).
- Accepts input samples on an AXI-Stream slave, stores each sample, computes y[n] = sum over k=0..10 of h[k]*x[n-k], and emits y on an AXI-Stream master.
- Runs under ap_start / ap_done / ap_idle control. Taps are preloaded by the configuration block before ap_start.

Parameters:
- DATA_W, 32, sample/tap/result width.
- NUM_TAP, 11, taps and data RAM depth.
- ADDR_W, 12, BRAM byte-address width.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- ap_start  in  1  one-cycle start pulse.
- data_length  in  32  number of samples per run.
- ap_idle  out  1  high in IDLE/DONE.
- ap_done  out  1  high in DONE until next accepted ap_start.
- ss_tvalid / ss_tdata[31:0] / ss_tlast  in  1/32/1  input stream.
- ss_tready  out  1  input ready.
- sm_tvalid / sm_tdata[31:0] / sm_tlast  out  1/32/1  output stream.
- sm_tready  in  1  output ready.
- tap_EN / tap_WE[3:0] / tap_A[11:0]  out  tap RAM controls (tap_WE always 0).
- tap_Do  in  32  tap RAM read data.
- data_EN / data_WE[3:0] / data_A[11:0] / data_Di[31:0]  out  data RAM controls.
- data_Do  in  32  data RAM read data.
- err_tlast  out  1  tlast mismatch flag.

Behaviour:
- Reset (any time, including mid-run): state=IDLE, all stream valids/readies 0, ap_idle=1, ap_done=0, EN/WE=0, addresses 0, wptr=0, sample count=0, accumulator=0, err_tlast=0.
- BRAM timing: address and WE are registered by the RAM on CLK. Read data is valid the cycle after the address is presented. A word written at an edge is readable at the next address.
- Byte address = word index << 2.
- IDLE: ap_start=1 -> CLEAR.
  - ap_start is ignored in every other state except DONE; in DONE it behaves as in IDLE.
- CLEAR: 11 cycles writing 0 to data words 0..10 (data_WE=4'hF). Then:
  - data_length==0 -> DONE;
  - otherwise -> WAIT_IN.
- WAIT_IN: ss_tready=1. On ss_tvalid, in the same cycle:
  - data_EN=1, data_WE=4'hF, data_A=wptr<<2, data_Di=ss_tdata;
  - -> MAC.
- MAC: for k=0..10 issue tap_A=k<<2 and data_A=((wptr-k) mod 11)<<2 on consecutive cycles.
  - The product of each pair is accumulated one cycle later.
  - Accumulator is cleared at the handshake.
  - The last accumulate lands 12 edges after the handshake edge -> OUT.
- OUT: sm_tvalid=1, sm_tdata=accumulator.
  - sm_tdata and sm_tlast are held stable until sm_tready.
  - sm_tlast=1 when this is sample number data_length.
  - On handshake: wptr=(wptr+1) mod 11, count+1, then -> DONE if count==data_length, else WAIT_IN.
- Latency: sm_tvalid rises exactly 12 cycles after the ss handshake edge. Throughput is at most 1 sample per 13 cycles.
- Arithmetic: signed 32x32 multiply. Accumulation is kept in 32 bits and wraps modulo 2^32 (no saturation).
- wptr wraps 10 -> 0. Samples before run start read as 0 because CLEAR zeroes the data RAM.
- ss_tready=0 in every state except WAIT_IN. sm_tvalid=0 in every state except OUT.

Optional Feature:
- Macro FIR_TLAST_CHECK_EN.
- Defined: at each input handshake, if ss_tlast != (count+1==data_length), err_tlast sets sticky. It clears on the next accepted ap_start or on reset.
- Undefined: err_tlast tied 0 and ss_tlast is ignored.

Decomposition:
- Package fir_pkg: NUM_TAP, DATA_W, ADDR_W, state encoding (IDLE, CLEAR, WAIT_IN, MAC, OUT, DONE), function computing a circular data index.
- Sub-module fir_mac: registered multiply-accumulate with synchronous clear and enable.

Test Plan:
- Taps h=1..11, data_length=11, input impulse 1,0,0,... -> outputs 1,2,...,11; sm_tlast only on sample 11; ap_done=1 afterwards.
- Taps all 1, inputs 1..15 -> y = 1,3,6,...,66, then 77,88,99,110 (window sum after wrap); verifies wptr wrap.
- Run two back-to-back jobs: second job's first output equals h[0]*x0 only, proving CLEAR; sm_tready held low 5 cycles -> sm_tdata stable, no lost or duplicated sample.
- data_length=0, ap_start -> no sm_tvalid; ap_done=1 after 11 clear cycles; ap_start during MAC ignored.
- RST_N low during MAC -> all outputs return to reset values immediately; the next run produces correct results.
- FIR_TLAST_CHECK_EN defined, ss_tlast asserted on sample 3 of 5 -> err_tlast=1 sticky; it clears on the next ap_start.
